// File: rtl/perf_trig_pkg.sv
// Shared types and constants for the performance event trigger master.
// Command encoding and the section/offset to byte-address helper.
package perf_trig_pkg;

    localparam int STOP_OFS          = 0;
    localparam int GO_OFS            = 1;
    localparam int WORDS_PER_SECTION = 4;
    localparam logic [31:0] GLOBAL_CLR_DATA = 32'h1;

    typedef enum logic {
        IDLE,
        WRITE
    } state_e;

    typedef enum logic [1:0] {
        CMD_STOP,
        CMD_GO,
        CMD_CLR
    } kind_e;

    typedef struct packed {
        kind_e      kind;
        logic [2:0] section;
    } cmd_t;

    // Byte offset from the slave base for a command.
    function automatic logic [31:0] cmd_byte_ofs(cmd_t c);
        logic [31:0] w_word;
        w_word = 32'(WORDS_PER_SECTION) * {29'd0, c.section};
        unique case (c.kind)
            CMD_GO:  w_word = w_word + 32'(GO_OFS);
            CMD_CLR: w_word = '0;
            default: w_word = w_word + 32'(STOP_OFS);
        endcase
        return w_word << 2;
    endfunction

endpackage

// File: rtl/perf_event_trigger_master_if.sv
// Avalon-MM write-only master bundle.
// Master drives request side; slave returns waitrequest.
interface perf_event_trigger_master_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_waitrequest;

    modport master (
        output avm_address,
        output avm_write,
        output avm_writedata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_write,
        input  avm_writedata,
        output avm_waitrequest
    );
endinterface

// File: rtl/perf_trig_arbiter.sv
// Fixed-priority selector over the pending flag vectors.
// Global clear first, then lowest section, STOP before GO.
module perf_trig_arbiter
    import perf_trig_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] i_go,
    input  logic [N-1:0] i_stop,
    input  logic         i_clr,
    output cmd_t         o_cmd,
    output logic         o_valid
);

    // Scan high to low so the lowest index overwrites last.
    always_comb begin
        o_cmd   = '{kind: CMD_STOP, section: 3'd0};
        o_valid = i_clr | (|i_go) | (|i_stop);
        for (int i = N - 1; i >= 0; i--) begin
            if (i_go[i])
                o_cmd = '{kind: CMD_GO, section: 3'(i)};
            if (i_stop[i])
                o_cmd = '{kind: CMD_STOP, section: 3'(i)};
        end
        if (i_clr)
            o_cmd = '{kind: CMD_CLR, section: 3'd0};
    end

endmodule

// File: rtl/perf_event_trigger_master.sv
// Turns event pulses into Avalon-MM STOP/GO writes to counter sections.
// Optional global clear request enabled by PERF_TRIG_GLOBAL_CLEAR_EN.
module perf_event_trigger_master
    import perf_trig_pkg::*;
#(
    parameter int          NUM_SECTIONS = 8,
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          DROP_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_SECTIONS-1:0] evt_go,
    input  logic [NUM_SECTIONS-1:0] evt_stop,
`ifdef PERF_TRIG_GLOBAL_CLEAR_EN
    input  logic                    clear_req,
`endif
    perf_event_trigger_master_if.master avm,
    output logic                    busy,
    output logic [DROP_W-1:0]       drop_count
);

    localparam int N = NUM_SECTIONS;

    logic [N-1:0]      r_pend_go;
    logic [N-1:0]      r_pend_stop;
    state_e            r_state;
    state_e            w_next;
    cmd_t              r_cmd;
    cmd_t              w_win;
    logic              w_valid;
    logic              w_accept;
    logic [ADDR_W-1:0] r_addr;
    logic [DROP_W-1:0] r_drop;
    logic [N-1:0]      w_clr_go;
    logic [N-1:0]      w_clr_stop;
    logic [N-1:0]      w_keep_go;
    logic [N-1:0]      w_keep_stop;
    logic              w_drop;
    logic              w_pend_clr;
    logic              w_clr_all;
    logic              w_clr_drop;
    logic [31:0]       w_data;

    assign w_accept = (r_state == WRITE) & ~avm.avm_waitrequest;

`ifdef PERF_TRIG_GLOBAL_CLEAR_EN
    logic        r_pend_clr;
    logic [31:0] r_data;

    assign w_clr_all  = w_accept & (r_cmd.kind == CMD_CLR);
    assign w_clr_drop = clear_req & r_pend_clr & ~w_clr_all;
    assign w_pend_clr = r_pend_clr;
    assign w_data     = r_data;

    // Sticky global clear request, dropped once its write lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_pend_clr <= 1'b0;
        else
            r_pend_clr <= clear_req | (r_pend_clr & ~w_clr_all);
    end

    // Write data latched with the address when a command starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_data <= '0;
        else if (r_state == IDLE && w_valid)
            r_data <= (w_win.kind == CMD_CLR) ? GLOBAL_CLR_DATA : 32'h0;
    end
`else
    assign w_clr_all  = 1'b0;
    assign w_clr_drop = 1'b0;
    assign w_pend_clr = 1'b0;
    assign w_data     = 32'h0;
`endif

    assign w_clr_go   = (w_accept && r_cmd.kind == CMD_GO)
                      ? (N'(1) << r_cmd.section) : '0;
    assign w_clr_stop = (w_accept && r_cmd.kind == CMD_STOP)
                      ? (N'(1) << r_cmd.section) : '0;
    assign w_keep_go   = r_pend_go & ~w_clr_go & ~{N{w_clr_all}};
    assign w_keep_stop = r_pend_stop & ~w_clr_stop & ~{N{w_clr_all}};
    assign w_drop = (|(evt_go & w_keep_go)) | (|(evt_stop & w_keep_stop))
                  | w_clr_drop;

    perf_trig_arbiter #(.N(N)) u_arb (
        .i_go    (r_pend_go),
        .i_stop  (r_pend_stop),
        .i_clr   (w_pend_clr),
        .o_cmd   (w_win),
        .o_valid (w_valid)
    );

    // Sticky per-section flags; a new pulse survives a same-edge clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_go   <= '0;
            r_pend_stop <= '0;
        end else begin
            r_pend_go   <= evt_go | w_keep_go;
            r_pend_stop <= evt_stop | w_keep_stop;
        end
    end

    // Saturating count of events that hit an already-pending flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_drop <= '0;
        else if (w_drop && r_drop != '1)
            r_drop <= r_drop + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // FSM next state; WRITE always returns to IDLE for one cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_valid) w_next = WRITE;
            WRITE:   if (w_accept) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Winner and address captured on IDLE->WRITE, then held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd  <= '{kind: CMD_STOP, section: 3'd0};
            r_addr <= '0;
        end else if (r_state == IDLE && w_valid) begin
            r_cmd  <= w_win;
            r_addr <= ADDR_W'(BASE_ADDR + cmd_byte_ofs(w_win));
        end
    end

    // FSM outputs and status.
    always_comb begin
        avm.avm_write     = (r_state == WRITE);
        avm.avm_address   = r_addr;
        avm.avm_writedata = w_data;
        busy       = (|r_pend_go) | (|r_pend_stop) | w_pend_clr
                   | (r_state == WRITE);
        drop_count = r_drop;
    end

endmodule

// File: tb/tb_perf_event_trigger_master.sv
// Scoreboard bench for perf_event_trigger_master.
// Define PERF_TRIG_GLOBAL_CLEAR_EN to also exercise the clear path.
module tb_perf_event_trigger_master;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  evt_go = '0;
    logic [7:0]  evt_stop = '0;
    logic        busy;
    logic [15:0] drop_count;
`ifdef PERF_TRIG_GLOBAL_CLEAR_EN
    logic        clear_req = 1'b0;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    logic        m_prev_wr = 1'b0;
    logic        m_prev_acc = 1'b0;
    logic [31:0] m_prev_a = '0;
    logic [31:0] m_prev_d = '0;

    perf_event_trigger_master_if #(.ADDR_W(32)) avm ();

    perf_event_trigger_master #(
        .NUM_SECTIONS (8),
        .ADDR_W       (32),
        .BASE_ADDR    (32'h0),
        .DROP_W       (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .evt_go     (evt_go),
        .evt_stop   (evt_stop),
`ifdef PERF_TRIG_GLOBAL_CLEAR_EN
        .clear_req  (clear_req),
`endif
        .avm        (avm.master),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ex(int k, int ofs);
        exp_t e;
        e.a = 32'((4 * k + ofs) * 4);
        e.d = 32'h0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(logic [7:0] g, logic [7:0] s);
        evt_go   = g;
        evt_stop = s;
        tick();
        evt_go   = '0;
        evt_stop = '0;
    endtask

    task automatic drain();
        for (int k = 0; k < 500; k++) begin
            if (!busy && sb.size() == 0)
                break;
            tick();
        end
        tick();
        chk("drain_busy", busy, 0);
        chk("drain_sb", sb.size(), 0);
    endtask

    // Monitor: pops on accepted writes, checks stall stability and idle gap.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            m_prev_wr  <= 1'b0;
            m_prev_acc <= 1'b0;
        end else begin
            if (m_prev_acc)
                chk("idle_gap", avm.avm_write, 0);
            if (avm.avm_write && m_prev_wr && !m_prev_acc) begin
                chk("hold_addr", avm.avm_address, m_prev_a);
                chk("hold_data", avm.avm_writedata, m_prev_d);
            end
            if (avm.avm_write && !avm.avm_waitrequest) begin
                chk("sb_depth", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("wr_addr", avm.avm_address, e.a);
                    chk("wr_data", avm.avm_writedata, e.d);
                end
            end
            m_prev_wr  <= avm.avm_write;
            m_prev_acc <= avm.avm_write & ~avm.avm_waitrequest;
            m_prev_a   <= avm.avm_address;
            m_prev_d   <= avm.avm_writedata;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        avm.avm_waitrequest = 1'b0;
        #2;
        chk("rst_write", avm.avm_write, 0);
        chk("rst_addr", avm.avm_address, 0);
        chk("rst_data", avm.avm_writedata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_count, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single GO, no stall: latency 2 edges.
        sb.push_back(ex(1, 1));
        pulse(8'h02, 8'h00);
        chk("t1_idle", avm.avm_write, 0);
        tick();
        chk("t1_write", avm.avm_write, 1);
        chk("t1_addr", avm.avm_address, 32'h14);
        tick();
        chk("t1_done", avm.avm_write, 0);
        drain();

        // STOP with 5 stalled cycles.
        avm.avm_waitrequest = 1'b1;
        sb.push_back(ex(3, 0));
        pulse(8'h00, 8'h08);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2_write", avm.avm_write, 1);
            chk("t2_addr", avm.avm_address, 32'h30);
            tick();
        end
        avm.avm_waitrequest = 1'b0;
        drain();

        // Priority ordering.
        sb.push_back(ex(0, 1));
        sb.push_back(ex(2, 0));
        sb.push_back(ex(2, 1));
        pulse(8'h05, 8'h04);
        drain();

        // Drops while stalled.
        avm.avm_waitrequest = 1'b1;
        sb.push_back(ex(4, 1));
        pulse(8'h10, 8'h00);
        tick();
        pulse(8'h10, 8'h00);
        tick();
        pulse(8'h10, 8'h00);
        chk("t4_drop2", drop_count, 2);
        avm.avm_waitrequest = 1'b0;
        drain();

        // Saturation.
        avm.avm_waitrequest = 1'b1;
        sb.push_back(ex(4, 1));
        evt_go = 8'h10;
        repeat (70010) tick();
        evt_go = 8'h00;
        chk("t4_sat", drop_count, 16'hFFFF);
        avm.avm_waitrequest = 1'b0;
        drain();

        // Reset during a stalled write.
        avm.avm_waitrequest = 1'b1;
        pulse(8'h40, 8'h00);
        tick();
        chk("t5_pre", avm.avm_write, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_write", avm.avm_write, 0);
        chk("t5_addr", avm.avm_address, 0);
        chk("t5_data", avm.avm_writedata, 0);
        chk("t5_busy", busy, 0);
        chk("t5_drop", drop_count, 0);
        tick();
        reset_n = 1'b1;
        avm.avm_waitrequest = 1'b0;
        repeat (20) tick();
        chk("t5_idle", avm.avm_write, 0);
        chk("t5_busy2", busy, 0);
        chk("t5_sb", sb.size(), 0);

`ifdef PERF_TRIG_GLOBAL_CLEAR_EN
        // Global clear wins and wipes the coincident GO.
        e.a = 32'h0;
        e.d = 32'h1;
        sb.push_back(e);
        clear_req = 1'b1;
        evt_go    = 8'h20;
        tick();
        clear_req = 1'b0;
        evt_go    = 8'h00;
        drain();
        chk("t6_drop", drop_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
